// File: rtl/input_port_flit_buffer.sv
// input_port_flit_buffer: credit-governed first-word-fall-through flit FIFO for one router input port.
// Returns one credit per consumed flit and flags any flit that arrives with no free slot.
module input_port_flit_buffer #(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flit_v_i,
    input  logic [FLIT_W-1:0] flit_i,
    output logic              credit_v_o,
    output logic              flit_v_o,
    output logic [FLIT_W-1:0] flit_o,
    input  logic              flit_ready_i,
    output logic [CNT_W-1:0]  occupancy_o,
    output logic              overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              full, pop, push_ok;
    assign full        = cnt == CNT_W'(DEPTH);
    assign pop         = flit_v_o && flit_ready_i;
    // a full buffer still accepts a flit when the head leaves in the same cycle
    assign push_ok     = flit_v_i && (!full || pop);
    assign flit_v_o    = cnt != '0;
    assign flit_o      = mem[rd_ptr];
    assign occupancy_o = cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            credit_v_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok != pop) cnt <= push_ok ? cnt + 1'b1 : cnt - 1'b1;
            credit_v_o <= pop;
            if (flit_v_i && full && !pop) overflow_o <= 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= flit_i;
    end
endmodule
